// File: rtl/lsq_fwd_pkg.sv
// rtl/lsq_fwd_pkg.sv - shared types and helpers for the load/store queue
package lsq_fwd_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    LD_MISS  = 2'd0,
    LD_FWD   = 2'd1,
    LD_STALL = 2'd2
  } ld_resp_kind_e;

  // Byte enables within the 32-bit word for an access of the given size at lane.
  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   byte_mask = 4'b0001 << lane;
      2'b01:   byte_mask = 4'b0011 << lane;
      default: byte_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsq_fwd_match.sv
// rtl/lsq_fwd_match.sv - age-ordered older-store search and forwarded byte extract/extend
module lsq_fwd_match
  import lsq_fwd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic [PTR_W-1:0]               head,
  input  logic [PTR_W-1:0]               ld_idx,
  input  logic [XLEN-1:0]                ld_addr,
  input  logic [2:0]                     ld_func3,
  input  logic [DEPTH-1:0]               ent_valid,
  input  logic [DEPTH-1:0]               ent_store,
  input  logic [DEPTH-1:0]               ent_resolved,
  input  logic [DEPTH-1:0][XLEN-3:0]     ent_waddr,
  input  logic [DEPTH-1:0][3:0]          ent_mask,
  input  logic [DEPTH-1:0][XLEN-1:0]     ent_data,
  output ld_resp_kind_e                  kind,
  output logic [XLEN-1:0]                data
);

  logic [3:0]       ld_mask;
  logic [PTR_W-1:0] ld_age;
  logic [PTR_W-1:0] j;
  logic             done;
  logic [XLEN-1:0]  hit_data;
  logic [XLEN-1:0]  shifted;
  logic [XLEN-1:0]  ext;

  assign ld_mask = byte_mask(ld_func3[1:0], ld_addr[1:0]);
  assign ld_age  = ld_idx - head;

  // Walk backwards from the load; the first relevant older store decides the outcome.
  always_comb begin
    kind     = LD_MISS;
    hit_data = '0;
    done     = 1'b0;
    j        = '0;
    for (int k = 1; k < DEPTH; k++) begin
      j = ld_idx - PTR_W'(k);
      if (!done && PTR_W'(k) <= ld_age && ent_valid[j] && ent_store[j]) begin
        if (!ent_resolved[j]) begin
          kind = LD_STALL;
          done = 1'b1;
        end else if (ent_waddr[j] == ld_addr[XLEN-1:2] && (ent_mask[j] & ld_mask) != 4'b0) begin
          done = 1'b1;
          if ((ld_mask & ~ent_mask[j]) != 4'b0) begin
            kind = LD_STALL;
          end else begin
            kind     = LD_FWD;
            hit_data = ent_data[j];
          end
        end
      end
    end
  end

  assign shifted = hit_data >> {ld_addr[1:0], 3'b000};

  always_comb begin
    ext = shifted;
    case (ld_func3)
      F3_B:    ext = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_H:    ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_BU:   ext = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_HU:   ext = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  assign data = (kind == LD_FWD) ? ext : '0;

endmodule

// File: rtl/lsq_fwd.sv
// rtl/lsq_fwd.sv - load/store queue with in-order commit and store-to-load forwarding
module lsq_fwd
  import lsq_fwd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             disp_valid,
  input  logic             disp_is_store,
  input  logic [TAG_W-1:0] disp_rob_tag,
  output logic             full,
  output logic             empty,
  input  logic             iss_valid,
  input  logic [TAG_W-1:0] iss_rob_tag,
  input  logic [XLEN-1:0]  iss_base,
  input  logic [XLEN-1:0]  iss_imm,
  input  logic [2:0]       iss_func3,
  input  logic [XLEN-1:0]  iss_ps2_data,
  input  logic [6:0]       iss_pd,
  output logic             ld_resp_valid,
  output logic [1:0]       ld_resp_kind,
  output logic [XLEN-1:0]  ld_resp_data,
  output logic [6:0]       ld_resp_pd,
  output logic [TAG_W-1:0] ld_resp_rob_tag,
  input  logic [TAG_W-1:0] rob_head,
  input  logic             commit,
  output logic             st_wb_valid,
  output logic [XLEN-1:0]  st_wb_addr,
  output logic [XLEN-1:0]  st_wb_data,
  output logic [3:0]       st_wb_be
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic             valid;
    logic             resolved;
    logic             is_store;
    logic [TAG_W-1:0] rob_tag;
    logic [XLEN-3:0]  waddr;
    logic [3:0]       mask;
    logic [XLEN-1:0]  data;
  } lsq_entry_t;

  lsq_entry_t       ent_q [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count;

  logic [XLEN-1:0]  iss_addr;
  logic             iss_hit;
  logic [PTR_W-1:0] iss_idx;
  logic             is_lookup;
  logic             do_commit;
  logic             do_alloc;

  logic [DEPTH-1:0]           v_valid, v_store, v_resolved;
  logic [DEPTH-1:0][XLEN-3:0] v_waddr;
  logic [DEPTH-1:0][3:0]      v_mask;
  logic [DEPTH-1:0][XLEN-1:0] v_data;
  ld_resp_kind_e              m_kind;
  logic [XLEN-1:0]            m_data;

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign iss_addr = iss_base + iss_imm;

  always_comb begin
    iss_hit = 1'b0;
    iss_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!iss_hit && ent_q[i].valid && !ent_q[i].resolved && ent_q[i].rob_tag == iss_rob_tag) begin
        iss_hit = 1'b1;
        iss_idx = PTR_W'(i);
      end
    end
  end

  assign is_lookup = iss_valid && iss_hit && !ent_q[iss_idx].is_store;
  assign do_commit = commit && ent_q[head].valid && ent_q[head].resolved &&
                     ent_q[head].rob_tag == rob_head;
  // A commit in the same cycle frees the head slot, so a full queue can still accept.
  assign do_alloc  = disp_valid && (!full || do_commit);

  always_comb begin
    v_valid = '0; v_store = '0; v_resolved = '0;
    v_waddr = '0; v_mask = '0;  v_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      v_valid[i]    = ent_q[i].valid;
      v_store[i]    = ent_q[i].is_store;
      v_resolved[i] = ent_q[i].resolved;
      v_waddr[i]    = ent_q[i].waddr;
      v_mask[i]     = ent_q[i].mask;
      v_data[i]     = ent_q[i].data;
    end
  end

  lsq_fwd_match #(.DEPTH(DEPTH), .XLEN(XLEN), .PTR_W(PTR_W)) u_match (
    .head         (head),
    .ld_idx       (iss_idx),
    .ld_addr      (iss_addr),
    .ld_func3     (iss_func3),
    .ent_valid    (v_valid),
    .ent_store    (v_store),
    .ent_resolved (v_resolved),
    .ent_waddr    (v_waddr),
    .ent_mask     (v_mask),
    .ent_data     (v_data),
    .kind         (m_kind),
    .data         (m_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head <= '0; tail <= '0; count <= '0;
      ld_resp_valid <= 1'b0; ld_resp_kind <= LD_MISS; ld_resp_data <= '0;
      ld_resp_pd <= '0; ld_resp_rob_tag <= '0;
      st_wb_valid <= 1'b0; st_wb_addr <= '0; st_wb_data <= '0; st_wb_be <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head <= '0; tail <= '0; count <= '0;
      ld_resp_valid <= 1'b0; ld_resp_kind <= LD_MISS; ld_resp_data <= '0;
      ld_resp_pd <= '0; ld_resp_rob_tag <= '0;
      st_wb_valid <= 1'b0; st_wb_addr <= '0; st_wb_data <= '0; st_wb_be <= '0;
    end else begin
      ld_resp_valid   <= is_lookup;
      ld_resp_kind    <= is_lookup ? m_kind : LD_MISS;
      ld_resp_data    <= is_lookup ? m_data : '0;
      ld_resp_pd      <= is_lookup ? iss_pd : '0;
      ld_resp_rob_tag <= is_lookup ? iss_rob_tag : '0;

      st_wb_valid <= do_commit && ent_q[head].is_store;
      st_wb_addr  <= (do_commit && ent_q[head].is_store) ? {ent_q[head].waddr, 2'b00} : '0;
      st_wb_data  <= (do_commit && ent_q[head].is_store) ? ent_q[head].data : '0;
      st_wb_be    <= (do_commit && ent_q[head].is_store) ? ent_q[head].mask : '0;

      // A stalled load stays unresolved so FU_mem's re-issue matches it again.
      if (iss_valid && iss_hit) begin
        ent_q[iss_idx].waddr    <= iss_addr[XLEN-1:2];
        ent_q[iss_idx].mask     <= byte_mask(iss_func3[1:0], iss_addr[1:0]);
        ent_q[iss_idx].data     <= iss_ps2_data << {iss_addr[1:0], 3'b000};
        ent_q[iss_idx].resolved <= !(is_lookup && m_kind == LD_STALL);
      end
      if (do_commit) begin
        ent_q[head].valid    <= 1'b0;
        ent_q[head].resolved <= 1'b0;
        head                 <= head + 1'b1;
      end
      if (do_alloc) begin
        ent_q[tail]          <= '0;
        ent_q[tail].valid    <= 1'b1;
        ent_q[tail].is_store <= disp_is_store;
        ent_q[tail].rob_tag  <= disp_rob_tag;
        tail                 <= tail + 1'b1;
      end
      count <= count + {{PTR_W{1'b0}}, do_alloc} - {{PTR_W{1'b0}}, do_commit};
    end
  end

endmodule
